cache_arbiter: RTL and testbench
================================

CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 Parameter LINE_W, default 256, cache line width in bits.
REQ-002 Parameter ADDR_W, default 32, byte address width.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 i_read  input  1  instruction-cache line read request; held until i_resp.
REQ-006 i_address  input  ADDR_W  instruction-cache line address.
REQ-007 i_rdata  output  LINE_W  line returned to the instruction cache.
REQ-008 i_resp  output  1  one-cycle completion pulse to the instruction cache.
REQ-009 d_read, d_write  input  1 each  data-cache line read / writeback request; held until d_resp.
REQ-010 d_address  input  ADDR_W  data-cache line address.
REQ-011 d_wdata  input  LINE_W  writeback line.
REQ-012 d_rdata  output  LINE_W  line returned to the data cache.
REQ-013 d_resp  output  1  one-cycle completion pulse to the data cache.
REQ-014 pmem_read, pmem_write  output  1 each  physical memory commands.
REQ-015 pmem_address  output  ADDR_W  physical memory line address.
REQ-016 pmem_wdata  output  LINE_W  physical memory write data.
REQ-017 pmem_rdata  input  LINE_W  physical memory read data.
REQ-018 pmem_resp  input  1  physical memory completion pulse.
REQ-019 contention_cnt  output  32  count of cycles in IDLE with both clients requesting.

Function
REQ-020 FSM states: IDLE, SERVE_I, SERVE_D_RD, SERVE_D_WR.
REQ-021 IDLE: register grant on the rising edge; no pmem command is driven in the same cycle as a first request (1-cycle grant latency).
REQ-022 Only one requester in IDLE: go to SERVE_I, SERVE_D_RD or SERVE_D_WR accordingly.
REQ-023 Both requesters in IDLE: grant the client not recorded in last_grant; last_grant resets to I, so D wins the first tie.
REQ-024 d_read and d_write asserted together: illegal; treat as a write (SERVE_D_WR).
REQ-025 SERVE_*: hold pmem_read/pmem_write, pmem_address and pmem_wdata constant until pmem_resp.
REQ-026 Forward pmem_address as the granted address with bits [4:0] forced to 0.
REQ-027 On pmem_resp in SERVE_*:
- pulse the granted client's resp in the same cycle;
- drive pmem_rdata onto that client's rdata combinationally;
- update last_grant;
- return to IDLE on the next edge.
REQ-028 Never assert i_resp and d_resp in the same cycle; never assert pmem_read and pmem_write together.
REQ-029 pmem_resp in IDLE: ignore.
REQ-030 A request dropped mid-service: still complete the transaction; still pulse the resp.
REQ-031 A client whose request is still high in the cycle after its resp: treat it as a new request from IDLE.
REQ-032 i_rdata/d_rdata outside their resp cycle: value is don't-care, but hold at pmem_rdata (no latch).
REQ-033 contention_cnt: increment by 1 per qualifying cycle; saturate at 32'hFFFF_FFFF (no wrap).

Reset
REQ-034 While rst_n is 0, apply immediately, without waiting for clk:
- state IDLE, last_grant I;
- contention_cnt 0;
- pmem_read, pmem_write, i_resp, d_resp all 0.
REQ-035 Reset mid-transaction aborts it: no resp is issued, and the pmem command deasserts asynchronously.
REQ-036 First grant is possible on the second rising edge after rst_n deasserts.

Structure
REQ-037 Package arbiter_types shall hold:
- arb_state_t enum;
- grant_t enum {GRANT_I, GRANT_D};
- LINE_W and ADDR_W defaults.
REQ-038 Tie-break logic shall live in sub-module arb_rr_select, with inputs req_i, req_d, last_grant and output grant.
REQ-039 The top shall be the FSM, the muxing and the counter only.

Verification
REQ-040 i_read=1, i_address=0x0000_0044; pmem_resp after 5 cycles:
- pmem_read=1 with pmem_address=0x0000_0040 one cycle after request;
- i_resp pulses once with i_rdata=pmem_rdata.
REQ-041 i_read and d_read rise the same cycle from reset:
- D served first, then I;
- contention_cnt=1;
- exactly two pmem_read transactions.
REQ-042 d_write=1, d_wdata=all 0xA5:
- pmem_write=1 and pmem_wdata stable until pmem_resp;
- d_resp one pulse;
- pmem_read stays 0.
REQ-043 Both requesters held continuously for 6 transactions: grants alternate D,I,D,I,D,I.
REQ-044 rst_n=0 two cycles into SERVE_I:
- pmem_read drops before the next clk edge;
- no i_resp;
- after release, a fresh i_read is served normally.
REQ-045 pmem_resp pulsed in IDLE with no requests: no resp outputs and no state change.

Source files
------------

// File: rtl/cache_arbiter_pkg.sv
// Shared types and default geometry for the I/D cache arbiter.
package arbiter_types;

  localparam int DEF_LINE_W = 256;
  localparam int DEF_ADDR_W = 32;

  // Lines are 32 bytes, so the low five address bits never reach memory.
  localparam int OFFSET_W = 5;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SERVE_I    = 2'd1,
    SERVE_D_RD = 2'd2,
    SERVE_D_WR = 2'd3
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

endpackage

// File: rtl/cache_arbiter_if.sv
// Client and physical-memory signal bundle around the arbiter.
// master: the environment (both caches plus the memory model).
// slave:  the arbiter itself.
interface cache_arbiter_if
  import arbiter_types::*;
#(
  parameter int LINE_W = DEF_LINE_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  // instruction cache
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  // data cache
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  // physical memory
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  modport master (
    output i_read, i_address, d_read, d_write, d_address, d_wdata,
           pmem_rdata, pmem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp,
           pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  modport slave (
    input  i_read, i_address, d_read, d_write, d_address, d_wdata,
           pmem_rdata, pmem_resp,
    output i_rdata, i_resp, d_rdata, d_resp,
           pmem_read, pmem_write, pmem_address, pmem_wdata
  );

endinterface

// File: rtl/cache_arbiter_rr_select.sv
// Two-way round-robin pick: a lone requester wins outright, a tie goes
// to whichever client was not served last.
module arb_rr_select
  import arbiter_types::*;
(
  input  logic   req_i,
  input  logic   req_d,
  input  grant_t last_grant,
  output grant_t grant
);

  // Combinational pick; with no request the output is ignored upstream.
  always_comb begin
    grant = GRANT_I;
    if (req_i && req_d)
      grant = (last_grant == GRANT_I) ? GRANT_D : GRANT_I;
    else if (req_d)
      grant = GRANT_D;
  end

endmodule

// File: rtl/cache_arbiter.sv
// Arbitrates instruction- and data-cache line traffic onto one physical
// memory port. Grant is registered out of IDLE; the granted address and
// write line are captured so the memory command stays stable even if the
// client drops its request before memory answers.
module cache_arbiter
  import arbiter_types::*;
#(
  parameter int LINE_W = DEF_LINE_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic        clk,
  input  logic        rst_n,
  cache_arbiter_if.slave bus,
  output logic [31:0] contention_cnt
);

  arb_state_t                   state_q, state_d;
  grant_t                       last_grant_q, last_grant_d;
  logic [ADDR_W-1:OFFSET_W]     addr_q, addr_d;
  logic [LINE_W-1:0]            wdata_q, wdata_d;
  logic [31:0]                  cnt_q, cnt_d;
  // Low for the first edge after reset release so the earliest grant
  // lands on the second edge.
  logic                         rdy_q;

  logic   req_i, req_d;
  grant_t grant;

  assign req_i = bus.i_read;
  assign req_d = bus.d_read | bus.d_write;

  arb_rr_select u_rr (
    .req_i      (req_i),
    .req_d      (req_d),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  // Read data is only meaningful in the resp cycle; pass it straight through.
  assign bus.i_rdata      = bus.pmem_rdata;
  assign bus.d_rdata      = bus.pmem_rdata;
  assign bus.pmem_address = {addr_q, {OFFSET_W{1'b0}}};
  assign bus.pmem_wdata   = wdata_q;
  assign contention_cnt   = cnt_q;

  // Next-state, capture and handshake outputs.
  always_comb begin
    state_d         = state_q;
    last_grant_d    = last_grant_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    cnt_d           = cnt_q;
    bus.pmem_read   = 1'b0;
    bus.pmem_write  = 1'b0;
    bus.i_resp      = 1'b0;
    bus.d_resp      = 1'b0;
    unique case (state_q)
      IDLE: begin
        // pmem_resp is ignored here; only requests move the FSM.
        if (rdy_q) begin
          if (req_i && req_d && (cnt_q != 32'hFFFF_FFFF))
            cnt_d = cnt_q + 32'd1;
          if (req_i || req_d) begin
            if (grant == GRANT_I) begin
              state_d = SERVE_I;
              addr_d  = bus.i_address[ADDR_W-1:OFFSET_W];
            end else begin
              // read+write together is treated as a writeback
              state_d = bus.d_write ? SERVE_D_WR : SERVE_D_RD;
              addr_d  = bus.d_address[ADDR_W-1:OFFSET_W];
              wdata_d = bus.d_wdata;
            end
          end
        end
      end
      SERVE_I: begin
        bus.pmem_read = 1'b1;
        if (bus.pmem_resp) begin
          bus.i_resp   = 1'b1;
          last_grant_d = GRANT_I;
          state_d      = IDLE;
        end
      end
      SERVE_D_RD: begin
        bus.pmem_read = 1'b1;
        if (bus.pmem_resp) begin
          bus.d_resp   = 1'b1;
          last_grant_d = GRANT_D;
          state_d      = IDLE;
        end
      end
      SERVE_D_WR: begin
        bus.pmem_write = 1'b1;
        if (bus.pmem_resp) begin
          bus.d_resp   = 1'b1;
          last_grant_d = GRANT_D;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, arbitration history, captured command and contention counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_I;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      rdy_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      rdy_q        <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: inputs change at negedge (or #1 after
// posedge), outputs are checked at negedge or #1 after an input change.
module tb_cache_arbiter;
  localparam int LW = 256;
  localparam int AW = 32;

  logic        clk;
  logic        rst_n;
  logic [31:0] contention_cnt;
  int          vecs;
  int          errs;

  cache_arbiter_if #(.LINE_W(LW), .ADDR_W(AW)) bus ();

  cache_arbiter #(.LINE_W(LW), .ADDR_W(AW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .contention_cnt (contention_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    bus.i_read     = 1'b0;
    bus.i_address  = '0;
    bus.d_read     = 1'b0;
    bus.d_write    = 1'b0;
    bus.d_address  = '0;
    bus.d_wdata    = '0;
    bus.pmem_rdata = '0;
    bus.pmem_resp  = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Wait (bounded) for a pmem command; sampled at negedge.
  task automatic wait_cmd(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.pmem_read || bus.pmem_write) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Raise pmem_resp with a data line; outputs settle after #1.
  task automatic respond(input logic [LW-1:0] data);
    bus.pmem_rdata = data;
    bus.pmem_resp  = 1'b1;
    #1;
  endtask

  task automatic end_resp();
    @(posedge clk);
    #1;
    bus.pmem_resp = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    bus.i_read = 1'b1;
    bus.d_write = 1'b1;
    @(negedge clk);
    vecs++; if (bus.pmem_read !== 1'b0) begin errs++; $display("FAIL reset_pmem_read got %b want 0", bus.pmem_read); end
    vecs++; if (bus.pmem_write !== 1'b0) begin errs++; $display("FAIL reset_pmem_write got %b want 0", bus.pmem_write); end
    vecs++; if (bus.i_resp !== 1'b0) begin errs++; $display("FAIL reset_i_resp got %b want 0", bus.i_resp); end
    vecs++; if (bus.d_resp !== 1'b0) begin errs++; $display("FAIL reset_d_resp got %b want 0", bus.d_resp); end
    vecs++; if (contention_cnt !== 32'd0) begin errs++; $display("FAIL reset_cnt got %0d want 0", contention_cnt); end
    clear_inputs();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_i();
    logic [LW-1:0] line;
    line = {8{32'hC0DE_0000}} ^ {{(LW-32){1'b0}}, 32'h0000_1234};
    bus.i_read    = 1'b1;
    bus.i_address = 32'h0000_0044;
    #1;
    vecs++; if (bus.pmem_read !== 1'b0) begin errs++; $display("FAIL single_i_no_same_cycle got %b want 0", bus.pmem_read); end
    @(negedge clk);
    vecs++; if (bus.pmem_read !== 1'b1) begin errs++; $display("FAIL single_i_read got %b want 1", bus.pmem_read); end
    vecs++; if (bus.pmem_address !== 32'h0000_0040) begin errs++; $display("FAIL single_i_addr got %h want 00000040", bus.pmem_address); end
    vecs++; if (bus.pmem_write !== 1'b0) begin errs++; $display("FAIL single_i_write got %b want 0", bus.pmem_write); end
    repeat (4) @(negedge clk);
    vecs++; if (bus.pmem_read !== 1'b1 || bus.i_resp !== 1'b0) begin errs++; $display("FAIL single_i_hold got rd=%b resp=%b want rd=1 resp=0", bus.pmem_read, bus.i_resp); end
    respond(line);
    vecs++; if (bus.i_resp !== 1'b1) begin errs++; $display("FAIL single_i_resp got %b want 1", bus.i_resp); end
    vecs++; if (bus.i_rdata !== line) begin errs++; $display("FAIL single_i_rdata got %h want %h", bus.i_rdata, line); end
    vecs++; if (bus.d_resp !== 1'b0) begin errs++; $display("FAIL single_i_d_resp got %b want 0", bus.d_resp); end
    bus.i_read = 1'b0;
    end_resp();
    @(negedge clk);
    vecs++; if (bus.i_resp !== 1'b0 || bus.pmem_read !== 1'b0) begin errs++; $display("FAIL single_i_after got resp=%b rd=%b want 0 0", bus.i_resp, bus.pmem_read); end
  endtask

  task automatic test_tie();
    bit ok;
    logic [LW-1:0] l1, l2;
    l1 = {LW{1'b1}};
    l2 = {32{8'h3C}};
    apply_reset();
    bus.i_read    = 1'b1;
    bus.i_address = 32'h0000_0100;
    bus.d_read    = 1'b1;
    bus.d_address = 32'h0000_0210;
    wait_cmd(ok);
    vecs++; if (!ok || bus.pmem_address !== 32'h0000_0200 || bus.pmem_read !== 1'b1) begin errs++; $display("FAIL tie_first_d got ok=%b addr=%h rd=%b want addr=00000200 rd=1", ok, bus.pmem_address, bus.pmem_read); end
    respond(l1);
    vecs++; if (bus.d_resp !== 1'b1 || bus.i_resp !== 1'b0 || bus.d_rdata !== l1) begin errs++; $display("FAIL tie_d_resp got d=%b i=%b want d=1 i=0 with data", bus.d_resp, bus.i_resp); end
    bus.d_read = 1'b0;
    end_resp();
    wait_cmd(ok);
    vecs++; if (!ok || bus.pmem_address !== 32'h0000_0100 || bus.pmem_read !== 1'b1) begin errs++; $display("FAIL tie_second_i got ok=%b addr=%h want 00000100", ok, bus.pmem_address); end
    respond(l2);
    vecs++; if (bus.i_resp !== 1'b1 || bus.d_resp !== 1'b0 || bus.i_rdata !== l2) begin errs++; $display("FAIL tie_i_resp got i=%b d=%b want i=1 d=0 with data", bus.i_resp, bus.d_resp); end
    bus.i_read = 1'b0;
    end_resp();
    repeat (3) @(negedge clk);
    vecs++; if (bus.pmem_read !== 1'b0) begin errs++; $display("FAIL tie_two_reads_only got rd=%b want 0", bus.pmem_read); end
    vecs++; if (contention_cnt !== 32'd1) begin errs++; $display("FAIL tie_cnt got %0d want 1", contention_cnt); end
  endtask

  task automatic test_write();
    bit ok;
    logic [LW-1:0] wl;
    wl = {32{8'hA5}};
    bus.d_write   = 1'b1;
    bus.d_address = 32'h1234_5678;
    bus.d_wdata   = wl;
    wait_cmd(ok);
    vecs++; if (!ok || bus.pmem_write !== 1'b1 || bus.pmem_read !== 1'b0) begin errs++; $display("FAIL write_cmd got ok=%b wr=%b rd=%b want 1 1 0", ok, bus.pmem_write, bus.pmem_read); end
    vecs++; if (bus.pmem_address !== 32'h1234_5660) begin errs++; $display("FAIL write_addr got %h want 12345660", bus.pmem_address); end
    // drop the request and scramble the inputs mid-service
    bus.d_write   = 1'b0;
    bus.d_wdata   = '0;
    bus.d_address = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    vecs++; if (bus.pmem_wdata !== wl || bus.pmem_write !== 1'b1 || bus.pmem_address !== 32'h1234_5660) begin errs++; $display("FAIL write_stable got wr=%b addr=%h want 1 12345660 and A5 data", bus.pmem_write, bus.pmem_address); end
    vecs++; if (bus.pmem_read !== 1'b0 || bus.d_resp !== 1'b0) begin errs++; $display("FAIL write_no_read got rd=%b resp=%b want 0 0", bus.pmem_read, bus.d_resp); end
    respond('0);
    vecs++; if (bus.d_resp !== 1'b1 || bus.i_resp !== 1'b0) begin errs++; $display("FAIL write_resp got d=%b i=%b want 1 0", bus.d_resp, bus.i_resp); end
    end_resp();
    @(negedge clk);
    vecs++; if (bus.d_resp !== 1'b0 || bus.pmem_write !== 1'b0) begin errs++; $display("FAIL write_one_pulse got resp=%b wr=%b want 0 0", bus.d_resp, bus.pmem_write); end
    // read and write together behave as a writeback
    bus.d_read    = 1'b1;
    bus.d_write   = 1'b1;
    bus.d_address = 32'h0000_0040;
    wait_cmd(ok);
    vecs++; if (!ok || bus.pmem_write !== 1'b1 || bus.pmem_read !== 1'b0) begin errs++; $display("FAIL rw_as_write got ok=%b wr=%b rd=%b want 1 1 0", ok, bus.pmem_write, bus.pmem_read); end
    respond('0);
    vecs++; if (bus.d_resp !== 1'b1) begin errs++; $display("FAIL rw_resp got %b want 1", bus.d_resp); end
    bus.d_read  = 1'b0;
    bus.d_write = 1'b0;
    end_resp();
  endtask

  task automatic test_alternate();
    bit ok;
    int who;
    apply_reset();
    bus.i_read    = 1'b1;
    bus.i_address = 32'h0000_1000;
    bus.d_read    = 1'b1;
    bus.d_address = 32'h0000_2000;
    for (int t = 0; t < 6; t++) begin
      wait_cmd(ok);
      vecs++; if (!ok) begin errs++; $display("FAIL alt_timeout txn=%0d got no command want command", t); end
      respond(LW'(t + 1));
      who = bus.d_resp ? 1 : (bus.i_resp ? 0 : 2);
      vecs++; if (who !== ((t % 2 == 0) ? 1 : 0) || (bus.i_resp && bus.d_resp)) begin errs++; $display("FAIL alt_grant txn=%0d got %0d want %0d (1=D 0=I)", t, who, (t % 2 == 0) ? 1 : 0); end
      end_resp();
    end
    bus.i_read = 1'b0;
    bus.d_read = 1'b0;
    repeat (2) @(negedge clk);
    vecs++; if (contention_cnt !== 32'd6) begin errs++; $display("FAIL alt_cnt got %0d want 6", contention_cnt); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    apply_reset();
    bus.i_read    = 1'b1;
    bus.i_address = 32'h0000_0080;
    wait_cmd(ok);
    @(negedge clk);
    vecs++; if (!ok || bus.pmem_read !== 1'b1) begin errs++; $display("FAIL mid_in_service got ok=%b rd=%b want 1 1", ok, bus.pmem_read); end
    rst_n      = 1'b0;
    bus.i_read = 1'b0;
    #1;
    vecs++; if (bus.pmem_read !== 1'b0) begin errs++; $display("FAIL mid_async_drop got rd=%b want 0", bus.pmem_read); end
    bus.pmem_resp = 1'b1;
    #1;
    vecs++; if (bus.i_resp !== 1'b0) begin errs++; $display("FAIL mid_no_resp got %b want 0", bus.i_resp); end
    @(negedge clk);
    bus.pmem_resp = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    vecs++; if (bus.pmem_read !== 1'b0 || bus.i_resp !== 1'b0) begin errs++; $display("FAIL mid_idle_after got rd=%b resp=%b want 0 0", bus.pmem_read, bus.i_resp); end
    bus.i_read    = 1'b1;
    bus.i_address = 32'h0000_01DF;
    wait_cmd(ok);
    vecs++; if (!ok || bus.pmem_address !== 32'h0000_01C0) begin errs++; $display("FAIL mid_fresh_addr got ok=%b addr=%h want 000001c0", ok, bus.pmem_address); end
    respond({LW{1'b0}} | LW'(32'hBEEF));
    vecs++; if (bus.i_resp !== 1'b1 || bus.i_rdata !== LW'(32'hBEEF)) begin errs++; $display("FAIL mid_fresh_resp got resp=%b want 1 with data", bus.i_resp); end
    bus.i_read = 1'b0;
    end_resp();
  endtask

  task automatic test_idle_resp();
    @(negedge clk);
    bus.pmem_resp = 1'b1;
    #1;
    vecs++; if (bus.i_resp !== 1'b0 || bus.d_resp !== 1'b0) begin errs++; $display("FAIL idle_resp got i=%b d=%b want 0 0", bus.i_resp, bus.d_resp); end
    @(negedge clk);
    bus.pmem_resp = 1'b0;
    vecs++; if (bus.pmem_read !== 1'b0 || bus.pmem_write !== 1'b0) begin errs++; $display("FAIL idle_no_move got rd=%b wr=%b want 0 0", bus.pmem_read, bus.pmem_write); end
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    test_reset();
    test_single_i();
    test_tie();
    test_write();
    test_alternate();
    test_reset_mid();
    test_idle_resp();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
